// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared definitions for the shared-multiplier arbiter:
//               controller state encoding and default sizing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Default operand width (product is twice this wide).
    localparam int c_DEFAULT_W   = 4;

    // Default number of cycles to wait for the multiplier before aborting.
    localparam int c_DEFAULT_TMO = 64;

    // Controller states: explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : mult_rr_pick
// Description : Combinational round-robin picker. Returns the index of the
//               first set request bit scanning ptr, ptr+1, ..., N-1, 0, ...
// Ports       : req [N]      - request vector
//               ptr [log2 N] - highest-priority index for this pick
//               sel [log2 N] - winning index (valid when any=1)
//               any          - at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module mult_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] sel,
    output logic                 any
);

    localparam int c_PW = $clog2(N);

    always_comb begin
        logic [c_PW:0] idx;
        idx = '0;
        sel = ptr;
        any = |req;
        // Walk offsets from farthest to nearest so the nearest set bit
        // (lowest offset from ptr) is the last assignment and wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (c_PW + 1)'(k);
            if (idx >= (c_PW + 1)'(N)) begin
                idx = idx - (c_PW + 1)'(N);
            end
            if (req[idx[c_PW-1:0]]) begin
                sel = idx[c_PW-1:0];
            end
        end
    end

endmodule : mult_rr_pick
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_arbiter
// Description : Shares one start/done shift-add multiplier between N
//               requesters. Round-robin grant, operand latch, start/done/
//               release sequencing, one-cycle ack with product, and a
//               timeout abort (err) if the multiplier never completes.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               req/a_in/b_in     - per-requester request and operands
//               ack/err/result    - completion pulse, abort pulse, product
//               busy              - controller not in IDLE
//               m_start/m_a/m_b   - multiplier control and operands
//               m_done/m_p        - multiplier completion and product
// Revision    : 1.0 - initial release
// ============================================================================
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int N   = 2,
    parameter int W   = c_DEFAULT_W,
    parameter int TMO = c_DEFAULT_TMO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   a_in,
    input  logic [N*W-1:0]   b_in,
    output logic [N-1:0]     ack,
    output logic             err,
    output logic [2*W-1:0]   result,
    output logic             busy,
    output logic             m_start,
    output logic [W-1:0]     m_a,
    output logic [W-1:0]     m_b,
    input  logic             m_done,
    input  logic [2*W-1:0]   m_p
);

    localparam int                c_PW       = $clog2(N);
    localparam int                c_TW       = $clog2(TMO) + 1;
    localparam logic [c_TW-1:0]   c_TMO_LAST = c_TW'(TMO - 1);
    localparam logic [c_PW-1:0]   c_PTR_LAST = c_PW'(N - 1);
    localparam logic [N-1:0]      c_ACK_LSB  = N'(1);

    state_t            r_state;
    logic [c_PW-1:0]   r_ptr;
    logic [c_PW-1:0]   r_sel;
    logic [c_TW-1:0]   r_timer;

    logic [c_PW-1:0]   w_sel;
    logic              w_any;
    logic [c_PW-1:0]   w_next_ptr;
    logic [W-1:0]      w_a [N];
    logic [W-1:0]      w_b [N];

    // Unpack the flat operand buses into per-requester slices.
    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign w_a[i] = a_in[i*W +: W];
        assign w_b[i] = b_in[i*W +: W];
    end

    mult_rr_pick #(
        .N   (N)
    ) u_pick (
        .req (req),
        .ptr (r_ptr),
        .sel (w_sel),
        .any (w_any)
    );

    assign w_next_ptr = (w_sel == c_PTR_LAST) ? '0 : w_sel + c_PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_timer <= '0;
            ack     <= '0;
            err     <= 1'b0;
            result  <= '0;
            busy    <= 1'b0;
            m_start <= 1'b0;
            m_a     <= '0;
            m_b     <= '0;
        end else begin
            // ack and err are single-cycle pulses.
            ack <= '0;
            err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_sel;
                        r_ptr   <= w_next_ptr;
                        m_a     <= w_a[w_sel];
                        m_b     <= w_b[w_sel];
                        busy    <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    m_start <= 1'b1;
                    r_timer <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_timer <= r_timer + c_TW'(1);
                    // Completion takes priority over a coincident timeout.
                    if (m_done) begin
                        result  <= m_p;
                        ack     <= c_ACK_LSB << r_sel;
                        m_start <= 1'b0;
                        r_state <= RELEASE;
                    end else if (r_timer == c_TMO_LAST) begin
                        err     <= 1'b1;
                        m_start <= 1'b0;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Hold off until the multiplier has dropped done so the
                    // next start is seen from its waiting state.
                    if (!m_done) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : mult_share_arbiter
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_share_arbiter
// Description : Self-checking bench for mult_share_arbiter (N=2, W=4, TMO=8)
//               with a behavioural start/done multiplier model and a
//               queue-based scoreboard of expected ack/err/result responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_share_arbiter;

    localparam int N   = 2;
    localparam int W   = 4;
    localparam int TMO = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   a_in;
    logic [N*W-1:0]   b_in;
    logic [N-1:0]     ack;
    logic             err;
    logic [2*W-1:0]   result;
    logic             busy;
    logic             m_start;
    logic [W-1:0]     m_a;
    logic [W-1:0]     m_b;
    logic             m_done;
    logic [2*W-1:0]   m_p;

    int checks = 0;
    int errors = 0;

    // Multiplier model controls.
    int done_delay   = 4;
    bit never_done   = 1'b0;
    int sticky_extra = 0;
    int mcnt = 0;
    int hold = 0;

    typedef struct packed {
        logic [N-1:0]   ack;
        logic           err;
        logic [2*W-1:0] result;
    } exp_t;

    exp_t sb[$];

    mult_share_arbiter #(
        .N       (N),
        .W       (W),
        .TMO     (TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .ack     (ack),
        .err     (err),
        .result  (result),
        .busy    (busy),
        .m_start (m_start),
        .m_a     (m_a),
        .m_b     (m_b),
        .m_done  (m_done),
        .m_p     (m_p)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: done rises done_delay cycles after start,
    // then stays high until start drops plus sticky_extra cycles.
    always @(posedge clk) begin
        if (rst) begin
            m_done <= 1'b0;
            m_p    <= '0;
            mcnt   <= 0;
            hold   <= 0;
        end else if (m_start && !m_done) begin
            if (!never_done && mcnt == done_delay - 1) begin
                m_done <= 1'b1;
                m_p    <= {4'd0, m_a} * {4'd0, m_b};
            end
            mcnt <= mcnt + 1;
        end else if (!m_start) begin
            mcnt <= 0;
            if (m_done) begin
                if (hold >= sticky_extra) begin
                    m_done <= 1'b0;
                    hold   <= 0;
                end else begin
                    hold <= hold + 1;
                end
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && (ack != '0 || err)) begin
            checks++;
            if (ack != '0 && err) begin
                errors++;
                $display("FAIL ack_err_excl: ack=%b err=%b both high", ack, err);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: ack=%b err=%b result=%0d, none expected", ack, err, result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (ack !== e.ack || err !== e.err || result !== e.result) begin
                    errors++;
                    $display("FAIL sb_resp: got ack=%b err=%b result=%0d expected ack=%b err=%b result=%0d",
                             ack, err, result, e.ack, e.err, e.result);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] a, input logic e, input logic [2*W-1:0] r);
        exp_t x;
        x.ack = a;
        x.err = e;
        x.result = r;
        sb.push_back(x);
    endtask

    task automatic set_ops(input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1);
        a_in = {a1, a0};
        b_in = {b1, b0};
    endtask

    task automatic wait_out(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (ack != '0 || err) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!busy) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        do_reset();

        // Reset state.
        chk("rst_ack", 32'(ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mstart", 32'(m_start), 0);
        chk("rst_ma", 32'(m_a), 0);
        chk("rst_mb", 32'(m_b), 0);

        // Single requester: 3*5.
        done_delay = 4;
        set_ops(4'd3, 4'd5, 4'd0, 4'd0);
        push(2'b01, 1'b0, 8'd15);
        req = 2'b01;
        step();
        chk("t1_busy_load", 32'(busy), 1);
        chk("t1_mstart_load", 32'(m_start), 0);
        chk("t1_ma", 32'(m_a), 3);
        chk("t1_mb", 32'(m_b), 5);
        step();
        chk("t1_mstart_lat2", 32'(m_start), 1);
        wait_out("t1_ack_seen");
        req = '0;
        chk("t1_busy_at_ack", 32'(busy), 1);
        step();
        chk("t1_busy_release", 32'(busy), 1);
        step();
        chk("t1_busy_idle", 32'(busy), 0);

        // Simultaneous requests after reset: 0 first, then 1.
        do_reset();
        set_ops(4'd2, 4'd7, 4'd15, 4'd15);
        push(2'b01, 1'b0, 8'd14);
        push(2'b10, 1'b0, 8'd225);
        req = 2'b11;
        wait_out("t2_first_seen");
        req = 2'b10;
        wait_out("t2_second_seen");
        req = '0;
        wait_idle("t2_idle");

        // Round-robin with both held: 0, 1, 0 (also shows ptr back at 0).
        push(2'b01, 1'b0, 8'd14);
        push(2'b10, 1'b0, 8'd225);
        push(2'b01, 1'b0, 8'd14);
        req = 2'b11;
        wait_out("t3_g1_seen");
        wait_out("t3_g2_seen");
        wait_out("t3_g3_seen");
        req = '0;
        wait_idle("t3_idle");

        // Timeout: no done, err TMO cycles after RUN entry, result kept.
        never_done = 1'b1;
        set_ops(4'd0, 4'd0, 4'd9, 4'd9);
        push(2'b00, 1'b1, 8'd14);
        req = 2'b10;
        cyc = 0;
        for (int i = 0; i < 20 && !m_start; i++) step();
        chk("t4_mstart_seen", 32'(m_start), 1);
        for (int i = 0; i < 40; i++) begin
            step();
            cyc++;
            if (err) break;
        end
        chk("t4_err_latency", 32'(cyc), TMO);
        chk("t4_no_ack", 32'(ack), 0);
        req = '0;
        wait_idle("t4_idle");
        never_done = 1'b0;

        // Reset mid-RUN.
        done_delay = 6;
        set_ops(4'd6, 4'd7, 4'd4, 4'd4);
        req = 2'b01;
        for (int i = 0; i < 20 && !m_start; i++) step();
        chk("t5_mstart_seen", 32'(m_start), 1);
        step();
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
        chk("t5_mstart", 32'(m_start), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_ack", 32'(ack), 0);
        chk("t5_result", 32'(result), 0);
        chk("t5_ma", 32'(m_a), 0);
        // ptr back at 0: requester 0 wins a tie.
        done_delay = 4;
        push(2'b01, 1'b0, 8'd42);
        push(2'b10, 1'b0, 8'd16);
        req = 2'b11;
        wait_out("t5_g1_seen");
        req = 2'b10;
        wait_out("t5_g2_seen");
        req = '0;
        wait_idle("t5_idle");

        // Done coincides with timer=TMO-1, done sticky 3 extra cycles.
        done_delay   = 7;
        sticky_extra = 3;
        set_ops(4'd13, 4'd11, 4'd0, 4'd0);
        push(2'b01, 1'b0, 8'd143);
        req = 2'b01;
        wait_out("t6_ack_seen");
        req = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!m_done) break;
            chk("t6_rel_mstart", 32'(m_start), 0);
            chk("t6_rel_busy", 32'(busy), 1);
        end
        chk("t6_busy_last", 32'(busy), 1);
        step();
        chk("t6_busy_idle", 32'(busy), 0);
        chk("t6_mstart_idle", 32'(m_start), 0);
        sticky_extra = 0;

        repeat (5) step();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mult_share_arbiter
`default_nettype wire

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one shift-add multiplier (start/done handshake, product width 2W) between N requesters.
- Arbitrates round-robin and latches the winner's operands into the multiplier.
- Sequences the multiplier's start/done/release cycle, returns the product with a one-cycle ack to the winner, and flags a timeout if the multiplier never completes.
- Sits between the requesting datapaths and the multiplier's control and datapath pair.

Parameters:
- N, 2, number of requesters (2..8).
- W, 4, operand width in bits; product is 2W bits.
- TMO, 64, maximum cycles to wait for m_done before aborting.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N  request per requester; operands must be stable while req=1
- a_in  in  N*W  operand A per requester; slice i is [i*W +: W]
- b_in  in  N*W  operand B per requester, same slicing
- ack  out  N  one-hot, one-cycle pulse: result valid for that requester
- err  out  1  one-cycle pulse when the served request was aborted on timeout
- result  out  2W  registered product, held until the next ack
- busy  out  1  high in every state except IDLE
- m_start  out  1  multiplier start, level
- m_a  out  W  registered operand A to the multiplier
- m_b  out  W  registered operand B to the multiplier
- m_done  in  1  multiplier done, level; stays high until m_start drops
- m_p  in  2W  multiplier product, valid while m_done=1

Behaviour:
- All outputs and internal registers are registered and update on the rising edge of clk.
- Reset (rst=1 at a clock edge), including mid-operation:
  - state=IDLE, round-robin pointer ptr=0, sel=0, timer=0.
  - ack, err, result, busy, m_start, m_a and m_b all return to 0.
  - The multiplier shares rst, so no release phase is needed after reset.
- FSM states: IDLE, LOAD, RUN, RELEASE.
- IDLE:
  - If req≠0, pick the winner sel: the first set bit of req scanning ptr, ptr+1, …, N-1, 0, … (wrap-around).
  - Latch m_a=a_in[sel], m_b=b_in[sel] and set ptr=(sel+1) mod N.
  - Go to LOAD. Requests arriving in other states wait; req is sampled only in IDLE.
- LOAD: assert m_start=1, clear timer, go to RUN. Latency from req to m_start is 2 cycles.
- RUN: hold m_start=1 and increment timer each cycle.
  - If m_done=1: result←m_p, ack[sel]=1 for exactly one cycle, m_start←0, go to RELEASE.
  - Else if timer=TMO-1: err=1 for one cycle, m_start←0, result unchanged, no ack, go to RELEASE.
  - If m_done and the timeout occur in the same cycle, m_done wins: the result is delivered and there is no err.
- RELEASE: m_start=0; wait for m_done=0, then go to IDLE. Guarantees the multiplier is back in its WAIT state before it is restarted.
- Requester protocol:
  - Drop req in the cycle after ack (or err).
  - A req still high when the FSM re-enters IDLE is treated as a new request.
- Minimum turnaround with a 1-cycle-done multiplier is 4 cycles (IDLE→LOAD→RUN→RELEASE→IDLE).
- Fairness: a continuously requesting master is served at most once per N grants while others are pending.
- Width rules:
  - Products are unsigned, 2W bits, with no truncation.
  - timer width is ceil(log2(TMO))+1.
  - ptr width is ceil(log2(N)); ptr wraps N-1→0.
- busy=0 only in IDLE.
- ack and err are never high in the same cycle.

Decomposition:
- Shared package mult_pkg holds:
  - the state encoding constants IDLE=2'd0, LOAD=2'd1, RUN=2'd2, RELEASE=2'd3;
  - the default W=4;
  - a TMO default constant.
- One sub-module is natural: mult_rr_pick, a combinational round-robin picker.
  - Inputs: req[N], ptr.
  - Outputs: sel (index) and any (request present).
  - Instantiated once in the arbiter and reusable by other shared-resource arbiters.

Test Plan:
- N=2, W=4, single requester: req=01, a=3, b=5, model done 4 cycles after start → m_start high 2 cycles after req, result=15, ack=01 for one cycle, err=0, busy falls after RELEASE.
- Simultaneous requests after reset: req=11, a0=2, b0=7, a1=15, b1=15 → requester 0 served first (result 14, ack=01), then requester 1 (result 225, ack=10); ptr=0 after both.
- Round-robin: after serving 0, hold req=11 → next grant goes to 1, then 0; no requester is served twice in a row while the other is pending.
- Timeout: TMO=8, model never asserts m_done → err pulses exactly 8 cycles after RUN entry, no ack, result keeps its previous value, FSM returns to IDLE.
- Reset mid-RUN: rst=1 for one cycle while m_start=1 → next cycle m_start=0, busy=0, ack=0, result=0, ptr=0; a subsequent request is served normally.
- Done/timeout collision plus sticky done: m_done rises exactly at timer=TMO-1 and stays high 3 extra cycles after m_start drops → ack issued with no err, FSM stays in RELEASE until m_done=0, no new m_start meanwhile.
